// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the data-memory access path.
// Contents: funct3 load/store encodings, access FSM state enum, byte-lane
// mask helper and access-legality helper.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'(4'b0001 << off);
      F3_H, F3_HU: m = 4'(4'b0011 << off);
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

  // Reserved encodings, unsigned stores, both commands at once, misalignment.
  function automatic logic illegal_access(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = rd & wr;
    case (f3)
      F3_B:    bad = bad;
      F3_BU:   bad = bad | wr;
      F3_H:    bad = bad | lo[0];
      F3_HU:   bad = bad | wr | lo[0];
      F3_W:    bad = bad | (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it to 32 bits.
// Ports: rdata_i (read word), offset_i (addr[1:0]), funct3_i (size/sign),
//        result_o (extended load value, combinational).
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {24'h000000, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result_o = {16'h0000, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage of the multi-cycle CPU.
// Accepts a load/store command pulse, checks legality, drives the data-memory
// req/ready handshake with lane-aligned data and byte enables, extends load
// data into the MDR and reports completion/error. All outputs are registered.
// Ports: CLK/RST (sync active-high), start/mem_read/mem_write/funct3/addr/wdata
//        (command), dm_* (memory port), busy/done/err/mdr (status to FSM).
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mdr
);

  // Wait counter runs 0..TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              load_q, load_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [31:0]       dm_addr_q, dm_addr_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       mdr_q, mdr_d;

  logic [31:0]       st_data;
  logic [31:0]       ld_val;

  // Extension uses the latched command, not the live inputs.
  load_extend u_load_extend (
    .rdata_i  (dm_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (ld_val)
  );

  // Store aligner: replicate the store element across all lanes.
  always_comb begin
    case (funct3)
      F3_B:    st_data = {4{wdata[7:0]}};
      F3_H:    st_data = {2{wdata[15:0]}};
      default: st_data = wdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    off_d      = off_q;
    load_d     = load_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mdr_d      = mdr_q;

    case (state_q)
      IDLE: begin
        if (start && (mem_read || mem_write)) begin
          f3_d   = funct3;
          off_d  = addr[1:0];
          load_d = mem_read & ~mem_write;
          cnt_d  = '0;
          if (illegal_access(mem_read, mem_write, funct3, addr[1:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = REQ;
            dm_req_d   = 1'b1;
            dm_we_d    = mem_write;
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_be_d    = lane_mask(funct3, addr[1:0]);
            dm_wdata_d = mem_write ? st_data : 32'h0;
          end
        end
      end

      REQ: begin
        if (dm_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d    = DONE;
          done_d     = 1'b1;
          err_d      = ~dm_ready;
          cnt_d      = '0;
          dm_req_d   = 1'b0;
          dm_we_d    = 1'b0;
          dm_addr_d  = 32'h0;
          dm_be_d    = 4'h0;
          dm_wdata_d = 32'h0;
          if (dm_ready && load_q) begin
            mdr_d = ld_val;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= 3'h0;
      off_q      <= 2'h0;
      load_q     <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_be_q    <= 4'h0;
      dm_wdata_q <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mdr_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      load_q     <= load_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mdr_q      <= mdr_d;
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_be    = dm_be_q;
  assign dm_wdata = dm_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mdr      = mdr_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage of the multi-cycle RISC-V CPU. It sits directly downstream of the control FSM's MEM state, receiving the memory command, funct3, ALU-computed address and store data, and drives the data-memory port through a req/ready handshake. It aligns store data and byte enables, sign- or zero-extends load data into the memory data register (MDR), and reports misaligned, illegal or timed-out accesses. It stalls the FSM via `busy` until completion.

## Interface
- `TIMEOUT`, 16, max cycles in REQ without `dm_ready` before abort (≥1)
- `CLK` in 1: single clock, rising edge
- `RST` in 1: synchronous, active-high reset
- `start` in 1: one-cycle command pulse from the control FSM
- `mem_read` in 1: load command, sampled with `start`
- `mem_write` in 1: store command, sampled with `start`
- `funct3` in 3: access size/sign, sampled with `start`
- `addr` in 32: byte address from the ALU, sampled with `start`
- `wdata` in 32: store data (rs2), sampled with `start`
- `dm_req` out 1: memory request
- `dm_we` out 1: 1 = write
- `dm_addr` out 32: word address, {addr[31:2], 2'b00}
- `dm_be` out 4: byte-lane enables
- `dm_wdata` out 32: lane-aligned store data
- `dm_ready` in 1: memory accepts/completes the request this cycle
- `dm_rdata` in 32: read word, valid when `dm_ready`=1
- `busy` out 1: access in progress; FSM must hold
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; 1 = access failed
- `mdr` out 32: extended load result

## Operation
- States: IDLE, REQ, DONE. All command fields latch into internal registers on accepted `start`.
- IDLE: `start`=1 with exactly one of `mem_read`/`mem_write` → check legality, then go to REQ. Legal → REQ; illegal → DONE with `err`=1 and no memory request. `start` with neither → ignored. `start` with both → illegal.
- Illegal conditions:
  - funct3 ∈ {011, 110, 111};
  - store funct3 ∈ {100, 101};
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- REQ: `dm_req`=1; `dm_we`, `dm_addr`, `dm_be` and `dm_wdata` are held stable until `dm_ready` is sampled high. On that edge go to DONE with `err`=0. A load latches the extended `dm_rdata` into `mdr` on the same edge.
- Timeout: the wait counter increments each REQ cycle. If `TIMEOUT` cycles pass with `dm_ready` low → DONE with `err`=1, `mdr` unchanged.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` = (state ≠ IDLE). `start` while busy is ignored.
- Store lanes, o = addr[1:0]:
  - SB: be = 0001<<o; wdata byte replicated ×4.
  - SH: be = 0011<<o; halfword replicated ×2.
  - SW: be = 1111.
- Load extract: select byte o / halfword o[1] of `dm_rdata`, then extend:
  - LB, LH: sign-extend;
  - LBU, LHU: zero-extend;
  - LW: pass through.
- `dm_be` is 0 and `dm_req` is 0 outside REQ. `dm_be` for loads = lanes read.

## Timing
- Reset (edge with `RST`=1): state IDLE, all outputs 0, `mdr`=0, wait counter 0. This applies mid-transaction: `dm_req` is low from the cycle after the reset edge.
- Latency: `start` at cycle 0 → REQ at cycle 1. With `dm_ready` first high at cycle k≥1, `done` is at k+1 and `mdr` is valid from k+1 until the next successful load.
- Zero-wait memory gives 3 cycles `start`→IDLE. Illegal access: `done`/`err` at cycle 1.
- Timeout: `done`/`err` at cycle `TIMEOUT`+1.
- `dm_ready` outside REQ is ignored.

## Structure
- Shared package `cpu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum (IDLE/REQ/DONE).
- Combinational sub-module `load_extend` (inputs: rdata, offset, funct3; output: 32-bit result), reused by any later cache/bypass path.
- Top-level block contains the FSM, command registers, wait counter and store aligner.

## Test plan
- LW, addr=0x100, `dm_ready` same cycle as req, rdata=0xDEADBEEF → `dm_addr`=0x100, `dm_be`=1111, `done` at cycle 2, `mdr`=0xDEADBEEF, `err`=0.
- LB, addr=0x103, rdata=0x80FF_0000 → `dm_be`=1000, `mdr`=0xFFFFFF80. Repeat as LBU → `mdr`=0x00000080.
- SH, addr=0x202, wdata=0x1234ABCD, `dm_ready` delayed 3 cycles → `dm_we`=1, `dm_be`=1100, `dm_wdata`=0xABCDABCD, stable for all 3 wait cycles, `done` at cycle 5.
- LW at addr=0x102, then SB with funct3=100 → no `dm_req`, `done`+`err`=1 at cycle 1, `mdr` unchanged.
- LW with `dm_ready` held low, `TIMEOUT`=16 → `dm_req` deasserts, `done`+`err` at cycle 17. A second `start` during busy is ignored.
- `RST` asserted during REQ → `dm_req`, `busy` and `mdr` all 0 next cycle. A new LW afterwards completes normally.
